// File: rtl/cordic_atan_seq.sv
// Arctangent table for the CORDIC datapath: round(atan(2^-i) * 2^30) rescaled to DATA_W bits.
// Serves single random-access reads and a valid/ready burst of entries 0..N_ITER-1.
module cordic_atan_seq #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = DATA_W - 2,
  parameter int N_ITER = 16,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam int               SH       = 30 - FRAC_W;
  localparam logic [31:0]      RND      = (32'd1 << SH) >> 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITER - 1);

  // From i = 10 on, atan(2^-i) * 2^30 rounds to exactly 2^(30-i); entry 31 rounds to 0.
  function automatic logic [29:0] atan_raw(input int i);
    case (i)
      0:       return 30'h3243F6A9;
      1:       return 30'h1DAC6705;
      2:       return 30'h0FADBAFD;
      3:       return 30'h07F56EA7;
      4:       return 30'h03FEAB77;
      5:       return 30'h01FFD55C;
      6:       return 30'h00FFFAAB;
      7:       return 30'h007FFF55;
      8:       return 30'h003FFFEB;
      9:       return 30'h001FFFFD;
      default: return (i <= 30) ? 30'(32'd1 << (30 - i)) : 30'd0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] scale(input logic [29:0] e);
    return DATA_W'(({2'b00, e} + RND) >> SH);
  endfunction

  logic [DATA_W-1:0] rom [32];

  for (genvar g = 0; g < 32; g++) begin : g_rom
    assign rom[g] = scale(atan_raw(g));
  end

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nx;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idx_nx      = idx_q + 1'b1;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_valid_d  = rd_en;
    rd_data_d   = rd_en ? rom[rd_addr] : rd_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      STREAM: begin
        // Entry cycle fetches beat 0 from the table; the burst then runs at one beat per cycle.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = rom[idx_q];
          out_last_d  = (idx_q == LAST_IDX);
        end else if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d      = idx_nx;
            out_data_d = rom[idx_nx];
            out_last_d = (idx_nx == LAST_IDX);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cordic_atan_seq.sv
// Scoreboard bench for cordic_atan_seq: a 16-bit/16-beat instance and a 24-bit/1-beat instance.
module tb_cordic_atan_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        rd_en_a, start_a, out_ready_a;
  logic [4:0]  rd_addr_a, out_idx_a;
  logic [15:0] rd_data_a, out_data_a;
  logic        rd_valid_a, busy_a, out_last_a, out_valid_a, done_a;

  logic        rd_en_b, start_b, out_ready_b;
  logic [4:0]  rd_addr_b, out_idx_b;
  logic [23:0] rd_data_b, out_data_b;
  logic        rd_valid_b, busy_b, out_last_b, out_valid_b, done_b;

  cordic_atan_seq #(.DATA_W(16), .FRAC_W(14), .N_ITER(16), .IDX_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .start(start_a), .busy(busy_a), .out_data(out_data_a),
    .out_idx(out_idx_a), .out_last(out_last_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .done(done_a));

  cordic_atan_seq #(.DATA_W(24), .FRAC_W(22), .N_ITER(1), .IDX_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .start(start_b), .busy(busy_b), .out_data(out_data_b),
    .out_idx(out_idx_b), .out_last(out_last_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .done(done_b));

  int errors = 0;
  int checks = 0;
  int busy_cnt_a = 0, done_cnt_a = 0, busy_cnt_b = 0, done_cnt_b = 0;

  // (entry + 2^15) >> 16 for entries 0..15
  logic [15:0] exp16 [16] = '{16'h3244, 16'h1DAC, 16'h0FAE, 16'h07F5, 16'h03FF, 16'h0200,
                              16'h0100, 16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008,
                              16'h0004, 16'h0002, 16'h0001, 16'h0001};

  // beat = {idx[4:0], last, data[23:0]}
  logic [29:0] sq_a [$];
  logic [29:0] sq_b [$];
  logic [23:0] rdq_a [$];
  logic [23:0] rdq_b [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing (scoreboard empty)", name, act);
  endtask

  always @(negedge clk) begin : mon
    logic [29:0] e;
    logic [23:0] r;
    if (rst_n) begin
      if (rd_valid_a) begin
        if (rdq_a.size() == 0) unexpected("rd_a", {16'h0, rd_data_a});
        else begin r = rdq_a.pop_front(); chk("rd_a", {16'h0, rd_data_a}, {8'h0, r}); end
      end
      if (rd_valid_b) begin
        if (rdq_b.size() == 0) unexpected("rd_b", {8'h0, rd_data_b});
        else begin r = rdq_b.pop_front(); chk("rd_b", {8'h0, rd_data_b}, {8'h0, r}); end
      end
      if (out_valid_a && out_ready_a) begin
        if (sq_a.size() == 0) unexpected("beat_a", {2'b0, out_idx_a, out_last_a, 8'h0, out_data_a});
        else begin
          e = sq_a.pop_front();
          chk("beat_a", {2'b0, out_idx_a, out_last_a, 8'h0, out_data_a}, {2'b0, e});
        end
      end
      if (out_valid_b && out_ready_b) begin
        if (sq_b.size() == 0) unexpected("beat_b", {2'b0, out_idx_b, out_last_b, out_data_b});
        else begin
          e = sq_b.pop_front();
          chk("beat_b", {2'b0, out_idx_b, out_last_b, out_data_b}, {2'b0, e});
        end
      end
      if (busy_a) busy_cnt_a++;
      if (done_a) done_cnt_a++;
      if (busy_b) busy_cnt_b++;
      if (done_b) done_cnt_b++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst_a();
    for (int i = 0; i < 16; i++) sq_a.push_back({5'(i), (i == 15), 8'h0, exp16[i]});
  endtask

  task automatic wait_beat_a(input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid_a && out_idx_a == 5'(idx)) && n < budget);
    if (!(out_valid_a && out_idx_a == 5'(idx))) begin
      checks++;
      errors++;
      $display("FAIL wait_beat_a: got out_idx=%0d valid=%0b expected idx %0d within %0d cycles",
               out_idx_a, out_valid_a, idx, budget);
    end
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a && n < budget);
    if (!done_a) begin
      checks++;
      errors++;
      $display("FAIL wait_done_a: got done=0 expected done within %0d cycles", budget);
    end
  endtask

  task automatic wait_done_b(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_b && n < budget);
    if (!done_b) begin
      checks++;
      errors++;
      $display("FAIL wait_done_b: got done=0 expected done within %0d cycles", budget);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl_a"}, {27'h0, busy_a, out_valid_a, out_last_a, done_a, rd_valid_a}, 32'h0);
    chk({name, "_dat_a"}, {11'h0, out_idx_a, out_data_a}, 32'h0);
    chk({name, "_rd_a"}, {16'h0, rd_data_a}, 32'h0);
    chk({name, "_b"}, {busy_b, out_valid_b, out_last_b, done_b, rd_valid_b, out_idx_b[2:0],
                       out_data_b | rd_data_b}, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin : stim
    int b0, d0;
    rst_n = 1'b0;
    rd_en_a = 0; rd_addr_a = '0; start_a = 0; out_ready_a = 1;
    rd_en_b = 0; rd_addr_b = '0; start_b = 0; out_ready_b = 1;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    step();
    rst_n = 1'b1;

    // random-access reads, last one leaves 0x1DAC to check hold
    step();
    rd_en_a = 1; rd_addr_a = 5'd0;  rdq_a.push_back(24'h3244);
    rd_en_b = 1; rd_addr_b = 5'd0;  rdq_b.push_back(24'h3243F7);
    step();
    rd_en_b = 0;
    rd_addr_a = 5'd20; rdq_a.push_back(24'h0000);
    step(); rd_addr_a = 5'd4;  rdq_a.push_back(24'h03FF);
    step(); rd_addr_a = 5'd15; rdq_a.push_back(24'h0001);
    step(); rd_addr_a = 5'd1;  rdq_a.push_back(24'h1DAC);
    step(); rd_en_a = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rd_hold_a", {15'h0, rd_valid_a, rd_data_a}, {15'h0, 1'b0, 16'h1DAC});

    // full burst with a simultaneous read
    b0 = busy_cnt_a; d0 = done_cnt_a;
    step();
    start_a = 1; rd_en_a = 1; rd_addr_a = 5'd2; rdq_a.push_back(24'h0FAE);
    push_burst_a();
    step();
    start_a = 0; rd_en_a = 0;
    wait_done_a(60);
    step(); step();
    chk("busy_cycles_a", busy_cnt_a - b0, 17);
    chk("done_pulses_a", done_cnt_a - d0, 1);
    chk("burst_drained_a", sq_a.size(), 0);
    chk("idle_a", {busy_a, out_valid_a}, 0);

    // backpressure at idx 4, ignored start at idx 7
    d0 = done_cnt_a;
    step();
    start_a = 1;
    push_burst_a();
    step();
    start_a = 0;
    wait_beat_a(3, 40);
    @(posedge clk); #1;
    out_ready_a = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_a", {10'h0, out_valid_a, out_idx_a, out_data_a}, {10'h0, 1'b1, 5'd4, 16'h03FF});
    end
    @(posedge clk); #1;
    out_ready_a = 1;
    wait_beat_a(7, 40);
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    wait_done_a(60);
    step(); step();
    chk("bp_done_pulses_a", done_cnt_a - d0, 1);
    chk("bp_drained_a", sq_a.size(), 0);

    // fresh burst after done
    d0 = done_cnt_a;
    step();
    start_a = 1;
    push_burst_a();
    step();
    start_a = 0;
    wait_done_a(60);
    step(); step();
    chk("rerun_done_a", done_cnt_a - d0, 1);
    chk("rerun_drained_a", sq_a.size(), 0);

    // async reset mid-burst at idx 5
    d0 = done_cnt_a;
    step();
    start_a = 1;
    push_burst_a();
    step();
    start_a = 0;
    wait_beat_a(5, 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    sq_a.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done_a", done_cnt_a - d0, 0);
    chk("midrst_idle_a", {busy_a, out_valid_a}, 0);

    // single-beat burst, 24-bit words
    b0 = busy_cnt_b; d0 = done_cnt_b;
    step();
    start_b = 1;
    sq_b.push_back({5'd0, 1'b1, 24'h3243F7});
    step();
    start_b = 0;
    wait_done_b(20);
    step(); step();
    chk("done_pulses_b", done_cnt_b - d0, 1);
    chk("busy_cycles_b", busy_cnt_b - b0, 2);
    chk("drained_b", sq_b.size(), 0);

    chk("rd_drained", rdq_a.size() + rdq_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
